// File: rtl/mem_port_arbiter.sv
// Two-port arbiter: icache refill (read-only) and data port sharing one memory.
// Counts conflict stall cycles and flags transactions that never complete.
module mem_port_arbiter #(
    parameter int unsigned TIMEOUT_CYCLES = 1024,
    parameter bit          FIXED_PRIO     = 1'b0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        i_valid,
    input  logic [31:0] i_addr,
    output logic        i_ready,
    output logic [31:0] i_rdata,
    input  logic        d_valid,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    input  logic [3:0]  d_wstrb,
    output logic        d_ready,
    output logic [31:0] d_rdata,
    output logic        mem_valid,
    output logic        mem_instr,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wstrb,
    input  logic        mem_ready,
    input  logic [31:0] mem_rdata,
    output logic [31:0] stall_cnt,
    output logic        timeout_err
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BUSY_I = 2'd1,
        BUSY_D = 2'd2
    } state_e;

    localparam logic [31:0] TO_LIM = TIMEOUT_CYCLES;
    localparam bit          TO_EN  = (TIMEOUT_CYCLES != 0);

    state_e      state_q, state_d;
    logic        last_i_q, last_i_d;
    logic [31:0] stall_cnt_q, stall_cnt_d;
    logic [31:0] wait_cnt_q, wait_cnt_d;
    logic        timeout_err_q, timeout_err_d;
    logic        tie_to_i;
    logic        stall_evt;

    // A tie goes to I under fixed priority, else to whoever did not win last.
    assign tie_to_i = FIXED_PRIO || !last_i_q;

    // State and last-grant register; reset drops any in-flight request.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            last_i_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            last_i_q <= last_i_d;
        end
    end

    // Next-state: grant from IDLE, hand over back-to-back on completion.
    always_comb begin
        state_d  = state_q;
        last_i_d = last_i_q;
        unique case (state_q)
            IDLE: begin
                if (i_valid && d_valid) begin
                    state_d = tie_to_i ? BUSY_I : BUSY_D;
                end else if (i_valid) begin
                    state_d = BUSY_I;
                end else if (d_valid) begin
                    state_d = BUSY_D;
                end
            end
            BUSY_I: begin
                if (mem_ready) begin
                    last_i_d = 1'b1;
                    state_d  = d_valid ? BUSY_D : IDLE;
                end
            end
            BUSY_D: begin
                if (mem_ready) begin
                    last_i_d = 1'b0;
                    state_d  = i_valid ? BUSY_I : IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Outputs: forward the owner's request, return completion to the owner only.
    always_comb begin
        mem_valid = 1'b0;
        mem_instr = 1'b0;
        mem_addr  = 32'h0;
        mem_wdata = 32'h0;
        mem_wstrb = 4'h0;
        i_ready   = 1'b0;
        d_ready   = 1'b0;
        i_rdata   = mem_rdata;
        d_rdata   = mem_rdata;
        unique case (state_q)
            BUSY_I: begin
                mem_valid = 1'b1;
                mem_instr = 1'b1;
                mem_addr  = i_addr;
                i_ready   = mem_ready & i_valid;
            end
            BUSY_D: begin
                mem_valid = 1'b1;
                mem_addr  = d_addr;
                mem_wdata = d_wdata;
                mem_wstrb = d_wstrb;
                d_ready   = mem_ready & d_valid;
            end
            default: begin
            end
        endcase
    end

    // A stall is any cycle where a requester waits while the other holds memory.
    always_comb begin
        stall_evt = 1'b0;
        unique case (state_q)
            IDLE:    stall_evt = i_valid & d_valid;
            BUSY_I:  stall_evt = d_valid;
            BUSY_D:  stall_evt = i_valid;
            default: stall_evt = 1'b0;
        endcase
    end

    // Stall counter wraps; wait counter saturates and latches the timeout flag.
    always_comb begin
        stall_cnt_d = stall_evt ? stall_cnt_q + 32'd1 : stall_cnt_q;
        wait_cnt_d  = 32'h0;
        if (state_q != IDLE && !mem_ready) begin
            if (wait_cnt_q >= TO_LIM) begin
                wait_cnt_d = wait_cnt_q;
            end else begin
                wait_cnt_d = wait_cnt_q + 32'd1;
            end
        end
        timeout_err_d = timeout_err_q;
        if (TO_EN && wait_cnt_d == TO_LIM) begin
            timeout_err_d = 1'b1;
        end
    end

    // Counter and sticky-flag registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_cnt_q   <= 32'h0;
            wait_cnt_q    <= 32'h0;
            timeout_err_q <= 1'b0;
        end else begin
            stall_cnt_q   <= stall_cnt_d;
            wait_cnt_q    <= wait_cnt_d;
            timeout_err_q <= timeout_err_d;
        end
    end

    assign stall_cnt   = stall_cnt_q;
    assign timeout_err = timeout_err_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: vector table, directed corner sequences,
// and random traffic against a transaction-level reference model.
module tb_mem_port_arbiter;

    localparam int unsigned TO_A = 8;

    logic        clk;
    logic        reset;
    logic        i_valid;
    logic [31:0] i_addr;
    logic        d_valid;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic [3:0]  d_wstrb;
    logic        mem_ready;
    logic [31:0] mem_rdata;

    logic        a_i_ready, a_d_ready, a_mem_valid, a_mem_instr, a_timeout;
    logic [31:0] a_i_rdata, a_d_rdata, a_mem_addr, a_mem_wdata, a_stall;
    logic [3:0]  a_mem_wstrb;
    logic        b_i_ready, b_d_ready, b_mem_valid, b_mem_instr, b_timeout;
    logic [31:0] b_i_rdata, b_d_rdata, b_mem_addr, b_mem_wdata, b_stall;
    logic [3:0]  b_mem_wstrb;

    mem_port_arbiter #(.TIMEOUT_CYCLES(TO_A), .FIXED_PRIO(1'b0)) u_a (
        .clk(clk), .reset(reset),
        .i_valid(i_valid), .i_addr(i_addr),
        .i_ready(a_i_ready), .i_rdata(a_i_rdata),
        .d_valid(d_valid), .d_addr(d_addr),
        .d_wdata(d_wdata), .d_wstrb(d_wstrb),
        .d_ready(a_d_ready), .d_rdata(a_d_rdata),
        .mem_valid(a_mem_valid), .mem_instr(a_mem_instr),
        .mem_addr(a_mem_addr), .mem_wdata(a_mem_wdata),
        .mem_wstrb(a_mem_wstrb), .mem_ready(mem_ready),
        .mem_rdata(mem_rdata), .stall_cnt(a_stall),
        .timeout_err(a_timeout)
    );

    mem_port_arbiter #(.TIMEOUT_CYCLES(0), .FIXED_PRIO(1'b1)) u_b (
        .clk(clk), .reset(reset),
        .i_valid(i_valid), .i_addr(i_addr),
        .i_ready(b_i_ready), .i_rdata(b_i_rdata),
        .d_valid(d_valid), .d_addr(d_addr),
        .d_wdata(d_wdata), .d_wstrb(d_wstrb),
        .d_ready(b_d_ready), .d_rdata(b_d_rdata),
        .mem_valid(b_mem_valid), .mem_instr(b_mem_instr),
        .mem_addr(b_mem_addr), .mem_wdata(b_mem_wdata),
        .mem_wstrb(b_mem_wstrb), .mem_ready(mem_ready),
        .mem_rdata(mem_rdata), .stall_cnt(b_stall),
        .timeout_err(b_timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int unsigned n_vec;
    int unsigned n_bad;

    task automatic chk(input string nm, input logic [127:0] act,
                       input logic [127:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Request-side outputs; owner fields only matter while mem_valid is up.
    function automatic logic [71:0] a_bus(input logic full);
        if (full)
            return {a_mem_valid, a_mem_instr, a_mem_addr, a_mem_wdata,
                    a_mem_wstrb, a_i_ready, a_d_ready};
        return {a_mem_valid, 1'b0, 32'h0, 32'h0, 4'h0, a_i_ready, a_d_ready};
    endfunction

    function automatic logic [71:0] b_bus();
        return {b_mem_valid, b_mem_instr, b_mem_addr, b_mem_wdata,
                b_mem_wstrb, b_i_ready, b_d_ready};
    endfunction

    task automatic idle_in();
        i_valid   = 1'b0;
        i_addr    = 32'h0;
        d_valid   = 1'b0;
        d_addr    = 32'h0;
        d_wdata   = 32'h0;
        d_wstrb   = 4'h0;
        mem_ready = 1'b0;
        mem_rdata = 32'h0;
    endtask

    task automatic rst_pulse();
        @(negedge clk);
        reset = 1'b1;
        idle_in();
        #1;
        chk("rst_out", {a_mem_valid, a_i_ready, a_d_ready, a_stall, a_timeout},
            {1'b0, 1'b0, 1'b0, 32'h0, 1'b0});
    endtask

    typedef struct packed {
        logic        rst;
        logic        iv;
        logic [31:0] ia;
        logic        dv;
        logic [31:0] da;
        logic [31:0] dw;
        logic [3:0]  ds;
        logic        mr;
        logic [31:0] md;
        logic        mv;
        logic        mi;
        logic [31:0] ma;
        logic [31:0] mw;
        logic [3:0]  ms;
        logic        ir;
        logic        dr;
        logic [31:0] st;
    } vec_t;

    localparam int NV = 19;
    vec_t tbl [NV];

    // Reference model state
    bit          m_busy, m_own_i, m_last_i, m_to;
    int unsigned m_wait;
    logic [31:0] m_stall;
    bit          pi, pd;
    logic [31:0] ai, ad, wd;
    logic [3:0]  sd;
    logic [71:0] e_bus;
    bit          other;

    initial begin
        n_vec = 0;
        n_bad = 0;
        reset = 1'b1;
        idle_in();

        //        rst   iv    ia        dv    da        dw            ds    mr    md            mv    mi    ma        mw            ms    ir    dr    st
        tbl[0]  = '{1'b1, 1'b0, 32'h0,   1'b0, 32'h0,    32'h0,        4'h0, 1'b0, 32'h0,        1'b0, 1'b0, 32'h0,    32'h0,        4'h0, 1'b0, 1'b0, 32'd0};
        tbl[1]  = '{1'b0, 1'b1, 32'h100, 1'b0, 32'h0,    32'h0,        4'h0, 1'b0, 32'h0,        1'b0, 1'b0, 32'h0,    32'h0,        4'h0, 1'b0, 1'b0, 32'd0};
        tbl[2]  = '{1'b0, 1'b1, 32'h100, 1'b0, 32'h0,    32'h0,        4'h0, 1'b0, 32'h0,        1'b1, 1'b1, 32'h100,  32'h0,        4'h0, 1'b0, 1'b0, 32'd0};
        tbl[3]  = '{1'b0, 1'b1, 32'h100, 1'b0, 32'h0,    32'h0,        4'h0, 1'b0, 32'h0,        1'b1, 1'b1, 32'h100,  32'h0,        4'h0, 1'b0, 1'b0, 32'd0};
        tbl[4]  = '{1'b0, 1'b1, 32'h100, 1'b0, 32'h0,    32'h0,        4'h0, 1'b1, 32'h13,       1'b1, 1'b1, 32'h100,  32'h0,        4'h0, 1'b1, 1'b0, 32'd0};
        tbl[5]  = '{1'b0, 1'b0, 32'h0,   1'b0, 32'h0,    32'h0,        4'h0, 1'b0, 32'h0,        1'b0, 1'b0, 32'h0,    32'h0,        4'h0, 1'b0, 1'b0, 32'd0};
        tbl[6]  = '{1'b0, 1'b0, 32'h0,   1'b1, 32'h2000, 32'hCAFEF00D, 4'h3, 1'b0, 32'h0,        1'b0, 1'b0, 32'h0,    32'h0,        4'h0, 1'b0, 1'b0, 32'd0};
        tbl[7]  = '{1'b0, 1'b0, 32'h0,   1'b1, 32'h2000, 32'hCAFEF00D, 4'h3, 1'b1, 32'h0,        1'b1, 1'b0, 32'h2000, 32'hCAFEF00D, 4'h3, 1'b0, 1'b1, 32'd0};
        tbl[8]  = '{1'b0, 1'b0, 32'h0,   1'b0, 32'h0,    32'h0,        4'h0, 1'b0, 32'h0,        1'b0, 1'b0, 32'h0,    32'h0,        4'h0, 1'b0, 1'b0, 32'd0};
        tbl[9]  = '{1'b1, 1'b0, 32'h0,   1'b0, 32'h0,    32'h0,        4'h0, 1'b0, 32'h0,        1'b0, 1'b0, 32'h0,    32'h0,        4'h0, 1'b0, 1'b0, 32'd0};
        tbl[10] = '{1'b0, 1'b1, 32'h40,  1'b1, 32'h80,   32'h11,       4'h0, 1'b0, 32'h0,        1'b0, 1'b0, 32'h0,    32'h0,        4'h0, 1'b0, 1'b0, 32'd0};
        tbl[11] = '{1'b0, 1'b1, 32'h40,  1'b1, 32'h80,   32'h11,       4'h0, 1'b1, 32'hAA,       1'b1, 1'b1, 32'h40,   32'h0,        4'h0, 1'b1, 1'b0, 32'd1};
        tbl[12] = '{1'b0, 1'b0, 32'h0,   1'b1, 32'h80,   32'h11,       4'h0, 1'b0, 32'h0,        1'b1, 1'b0, 32'h80,   32'h11,       4'h0, 1'b0, 1'b0, 32'd2};
        tbl[13] = '{1'b0, 1'b0, 32'h0,   1'b1, 32'h80,   32'h11,       4'h0, 1'b1, 32'hBB,       1'b1, 1'b0, 32'h80,   32'h11,       4'h0, 1'b0, 1'b1, 32'd2};
        tbl[14] = '{1'b0, 1'b0, 32'h0,   1'b0, 32'h0,    32'h0,        4'h0, 1'b0, 32'h0,        1'b0, 1'b0, 32'h0,    32'h0,        4'h0, 1'b0, 1'b0, 32'd2};
        tbl[15] = '{1'b0, 1'b1, 32'h200, 1'b0, 32'h0,    32'h0,        4'h0, 1'b0, 32'h0,        1'b0, 1'b0, 32'h0,    32'h0,        4'h0, 1'b0, 1'b0, 32'd2};
        tbl[16] = '{1'b0, 1'b0, 32'h200, 1'b0, 32'h0,    32'h0,        4'h0, 1'b0, 32'h0,        1'b1, 1'b1, 32'h200,  32'h0,        4'h0, 1'b0, 1'b0, 32'd2};
        tbl[17] = '{1'b0, 1'b0, 32'h200, 1'b0, 32'h0,    32'h0,        4'h0, 1'b1, 32'h0,        1'b1, 1'b1, 32'h200,  32'h0,        4'h0, 1'b0, 1'b0, 32'd2};
        tbl[18] = '{1'b0, 1'b0, 32'h0,   1'b0, 32'h0,    32'h0,        4'h0, 1'b1, 32'h0,        1'b0, 1'b0, 32'h0,    32'h0,        4'h0, 1'b0, 1'b0, 32'd2};

        for (int k = 0; k < NV; k++) begin
            @(negedge clk);
            reset     = tbl[k].rst;
            i_valid   = tbl[k].iv;
            i_addr    = tbl[k].ia;
            d_valid   = tbl[k].dv;
            d_addr    = tbl[k].da;
            d_wdata   = tbl[k].dw;
            d_wstrb   = tbl[k].ds;
            mem_ready = tbl[k].mr;
            mem_rdata = tbl[k].md;
            #1;
            chk($sformatf("vec%0d_bus", k), a_bus(tbl[k].mv),
                {tbl[k].mv, tbl[k].mi, tbl[k].ma, tbl[k].mw,
                 tbl[k].ms, tbl[k].ir, tbl[k].dr});
            chk($sformatf("vec%0d_stall", k), a_stall, tbl[k].st);
            if (tbl[k].ir)
                chk($sformatf("vec%0d_i_rdata", k), a_i_rdata, tbl[k].md);
        end

        // Tie-break after a lone I grant: round-robin gives D, fixed gives I.
        rst_pulse();
        @(negedge clk);
        reset     = 1'b0;
        i_valid   = 1'b1;
        i_addr    = 32'h10;
        mem_ready = 1'b1;
        @(negedge clk);
        #1;
        chk("prio_single_i", {a_i_ready, b_i_ready}, 2'b11);
        @(negedge clk);
        i_valid   = 1'b1;
        d_valid   = 1'b1;
        d_addr    = 32'h20;
        mem_ready = 1'b0;
        #1;
        chk("prio_idle", {a_mem_valid, b_mem_valid}, 2'b00);
        @(negedge clk);
        #1;
        chk("prio_rr_grant", a_bus(1'b1),
            {1'b1, 1'b0, 32'h20, 32'h0, 4'h0, 1'b0, 1'b0});
        chk("prio_fixed_grant", b_bus(),
            {1'b1, 1'b1, 32'h10, 32'h0, 4'h0, 1'b0, 1'b0});
        chk("prio_stall", {a_stall, b_stall}, {32'd1, 32'd1});

        // Memory that never answers: flag after TO_A busy cycles, stays set.
        rst_pulse();
        @(negedge clk);
        reset   = 1'b0;
        d_valid = 1'b1;
        d_addr  = 32'h44;
        for (int n = 0; n <= 10; n++) begin
            @(negedge clk);
            #1;
            chk($sformatf("to_busy%0d", n), a_mem_valid, 1'b1);
            chk($sformatf("to_flag%0d", n), {a_timeout, b_timeout},
                {(n >= int'(TO_A)), 1'b0});
        end
        @(negedge clk);
        mem_ready = 1'b1;
        #1;
        chk("to_late_ready", a_d_ready, 1'b1);
        @(negedge clk);
        d_valid   = 1'b0;
        mem_ready = 1'b0;
        #1;
        chk("to_sticky", {a_mem_valid, a_timeout, b_timeout}, 3'b010);

        // Reset in the middle of a data transaction.
        rst_pulse();
        @(negedge clk);
        reset   = 1'b0;
        d_valid = 1'b1;
        d_addr  = 32'h90;
        @(negedge clk);
        #1;
        chk("mid_busy_d", {a_mem_valid, a_mem_instr}, 2'b10);
        reset     = 1'b1;
        mem_ready = 1'b1;
        #1;
        chk("mid_rst", {a_mem_valid, a_d_ready, b_mem_valid, b_d_ready}, 4'b0);
        @(negedge clk);
        reset     = 1'b0;
        d_valid   = 1'b0;
        mem_ready = 1'b0;
        i_valid   = 1'b1;
        i_addr    = 32'h123;
        #1;
        chk("post_rst_idle", a_mem_valid, 1'b0);
        @(negedge clk);
        #1;
        chk("post_rst_grant", a_bus(1'b1),
            {1'b1, 1'b1, 32'h123, 32'h0, 4'h0, 1'b0, 1'b0});
        @(negedge clk);
        mem_ready = 1'b1;
        #1;
        chk("post_rst_ready", {a_i_ready, a_d_ready, a_stall}, {2'b10, 32'd0});

        // Random traffic on the round-robin instance.
        rst_pulse();
        m_busy   = 1'b0;
        m_own_i  = 1'b0;
        m_last_i = 1'b0;
        m_to     = 1'b0;
        m_wait   = 0;
        m_stall  = 32'h0;
        pi       = 1'b0;
        pd       = 1'b0;
        ai       = 32'h0;
        ad       = 32'h0;
        wd       = 32'h0;
        sd       = 4'h0;
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            reset = 1'b0;
            if (!pi && ($urandom % 3) == 0) begin
                pi = 1'b1;
                ai = $urandom;
            end
            if (!pd && ($urandom % 3) == 0) begin
                pd = 1'b1;
                ad = $urandom;
                wd = $urandom;
                sd = 4'($urandom);
            end
            i_valid   = pi;
            i_addr    = ai;
            d_valid   = pd;
            d_addr    = ad;
            d_wdata   = wd;
            d_wstrb   = sd;
            mem_ready = 1'($urandom);
            mem_rdata = $urandom;
            #1;
            if (!m_busy)
                e_bus = {1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 1'b0};
            else if (m_own_i)
                e_bus = {1'b1, 1'b1, ai, 32'h0, 4'h0, mem_ready & pi, 1'b0};
            else
                e_bus = {1'b1, 1'b0, ad, wd, sd, 1'b0, mem_ready & pd};
            chk($sformatf("rnd%0d_bus", c), a_bus(m_busy), e_bus);
            chk($sformatf("rnd%0d_cnt", c), {a_stall, a_timeout},
                {m_stall, m_to});
            chk($sformatf("rnd%0d_rdata", c),
                {a_i_rdata, a_d_rdata, b_i_rdata, b_d_rdata},
                {mem_rdata, mem_rdata, mem_rdata, mem_rdata});
            if (!m_busy) begin
                if (pi && pd) begin
                    m_stall = m_stall + 32'd1;
                    m_own_i = !m_last_i;
                    m_busy  = 1'b1;
                end else if (pi || pd) begin
                    m_own_i = pi;
                    m_busy  = 1'b1;
                end
                m_wait = 0;
            end else begin
                other = m_own_i ? pd : pi;
                if (other)
                    m_stall = m_stall + 32'd1;
                if (mem_ready) begin
                    m_last_i = m_own_i;
                    if (m_own_i)
                        pi = 1'b0;
                    else
                        pd = 1'b0;
                    m_wait = 0;
                    if (other)
                        m_own_i = !m_own_i;
                    else
                        m_busy = 1'b0;
                end else begin
                    if (m_wait < TO_A)
                        m_wait++;
                    if (m_wait == TO_A)
                        m_to = 1'b1;
                end
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
